// File: rtl/cfg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_scan_pkg
// Purpose  : Shared definitions for the configuration scan-chain controller:
//            controller state encoding, default geometry and the bit-counter
//            width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cfg_scan_pkg;

    localparam int unsigned DEFAULT_NUM_CHAINS = 4;
    localparam int unsigned DEFAULT_CHAIN_LEN  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter only has to reach CHAIN_LEN-1; CHAIN_LEN==2 still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_scan_lane.sv
`default_nettype none
// ============================================================================
// Module   : cfg_scan_lane
// Purpose  : One configuration shift chain plus its shadow register. The
//            chain shifts left (new bit enters at the LSB); the shadow captures
//            the whole chain in a single cycle on commit.
// Ports    : CK        - clock
//            RST       - synchronous active-high reset
//            shift_en  - shift si into the chain this cycle
//            commit_en - copy the chain into the shadow this cycle
//            si        - serial input bit
//            so        - chain MSB (readback of previous contents)
//            q         - committed shadow contents
// Revision : 1.0 - initial release
// ============================================================================
module cfg_scan_lane
    import cfg_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 shift_en,
    input  logic                 commit_en,
    input  logic                 si,
    output logic                 so,
    output logic [CHAIN_LEN-1:0] q
);

    logic [CHAIN_LEN-1:0] r_chain;
    logic [CHAIN_LEN-1:0] r_shadow;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_chain  <= '0;
            r_shadow <= '0;
        end else begin
            if (shift_en) begin
                r_chain <= {r_chain[CHAIN_LEN-2:0], si};
            end
            if (commit_en) begin
                r_shadow <= r_chain;
            end
        end
    end

    assign so = r_chain[CHAIN_LEN-1];
    assign q  = r_shadow;

endmodule

`default_nettype wire

// File: rtl/cfg_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cfg_scan_chain_ctrl
// Purpose  : Loads NUM_CHAINS parallel configuration chains of CHAIN_LEN bits
//            through a valid/ready word interface, then commits all chains
//            atomically into shadow registers that drive fabric configuration.
//            Previous chain contents are read back serially on scan_out.
// Ports    : CK         - clock
//            RST        - synchronous active-high reset
//            start      - begin a load (honoured in IDLE only)
//            abort      - cancel a load (honoured in SHIFT only)
//            word_in    - one bit per chain
//            word_valid - word_in is valid
//            word_ready - controller accepts a word this cycle
//            scan_out   - MSB of each chain
//            cfg_q      - committed configuration, chain c at [c*CHAIN_LEN +: CHAIN_LEN]
//            busy       - controller not idle
//            done       - one-cycle pulse after commit
// Revision : 1.0 - initial release
// ============================================================================
module cfg_scan_chain_ctrl
    import cfg_scan_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DEFAULT_NUM_CHAINS,
    parameter int unsigned CHAIN_LEN  = DEFAULT_CHAIN_LEN
) (
    input  logic                            CK,
    input  logic                            RST,
    input  logic                            start,
    input  logic                            abort,
    input  logic [NUM_CHAINS-1:0]           word_in,
    input  logic                            word_valid,
    output logic                            word_ready,
    output logic [NUM_CHAINS-1:0]           scan_out,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_q,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_shift_en;
    logic             w_commit_en;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Abort wins over a same-cycle accept: the chains must not move on the
    // cycle the load is cancelled. The final accept leaves the counter at
    // CHAIN_LEN-1 rather than wrapping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (word_valid) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == c_last_idx) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            COMMIT: w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake and status decode from state only, so word_ready never
    // depends combinationally on word_valid.
    assign word_ready  = (r_state == SHIFT);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign w_commit_en = (r_state == COMMIT);

    for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_lane
        cfg_scan_lane #(
            .CHAIN_LEN (CHAIN_LEN)
        ) u_lane (
            .CK        (CK),
            .RST       (RST),
            .shift_en  (w_shift_en),
            .commit_en (w_commit_en),
            .si        (word_in[g]),
            .so        (scan_out[g]),
            .q         (cfg_q[g*CHAIN_LEN +: CHAIN_LEN])
        );
    end

endmodule

`default_nettype wire

// File: doc/cfg_scan_chain_ctrl.md
# cfg_scan_chain_ctrl

Parametrised configuration-chain controller. It generalises the single-bit scan flip-flop into `NUM_CHAINS` parallel shift chains of `CHAIN_LEN` bits each. Bitstream words are loaded through a valid/ready handshake, and the result is committed atomically to a shadow register that drives fabric configuration. The block sits between the bitstream loader and the programmable routing/LUT configuration bits. It also provides serial readback of the previous chain contents.

## Interface
- `NUM_CHAINS`, default 4: number of parallel chains, ≥1; one bit per chain per accepted word.
- `CHAIN_LEN`, default 16: bits per chain, ≥2.
- `CK` input 1: clock; all state updates on rising edge.
- `RST` input 1: reset. Synchronous, active-high.
- `start` input 1: begin a load; sampled only in IDLE.
- `abort` input 1: cancel a load in SHIFT; shadow is left unchanged.
- `word_in` input `NUM_CHAINS`: bit c goes to chain c.
- `word_valid` input 1: `word_in` valid.
- `word_ready` output 1: block can accept a word.
- `scan_out` output `NUM_CHAINS`: MSB of each shift chain (readback bit shifted out).
- `cfg_q` output `NUM_CHAINS*CHAIN_LEN`: committed configuration; chain c occupies bits `[c*CHAIN_LEN +: CHAIN_LEN]`.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse after commit.

## Operation
- FSM states: IDLE, SHIFT, COMMIT, DONE.
- **IDLE → SHIFT** on `start && !abort`; bit counter cleared to 0.
- **SHIFT**
  - `word_ready`=1.
  - Accept occurs when `word_valid && word_ready`.
  - On accept, every chain c shifts left: `chain[c] <= {chain[c][CHAIN_LEN-2:0], word_in[c]}`. The first accepted bit ends at the MSB after `CHAIN_LEN` accepts.
  - On accept, the counter increments.
  - **SHIFT → COMMIT** on the accept made while counter == `CHAIN_LEN-1`.
  - `abort` in SHIFT has priority over an accept in the same cycle. That cycle shifts nothing, and the FSM goes to IDLE. Shift chains keep their partial contents; `cfg_q` is untouched.
- **COMMIT**: shadow ← all chains in one cycle; → DONE. `abort` is ignored.
- **DONE**: `done`=1; → IDLE.
- `start` outside IDLE is ignored. `abort` outside SHIFT is ignored.
- `scan_out` always reflects the current chain MSBs. During a full load it presents the previous chain contents MSB-first, one bit per accept.
- Counter width is `$clog2(CHAIN_LEN)`; it never wraps past `CHAIN_LEN-1`.
- Gaps in `word_valid` stall shifting with no state change.

## Timing
- Reset (synchronous, `RST`=1 at an edge) sets:
  - state IDLE, counter 0;
  - all chains 0, `cfg_q` all 0;
  - `word_ready`=0, `busy`=0, `done`=0, `scan_out`=0.
- `RST` mid-operation (any state) has the same effect. A partial load is discarded and `cfg_q` is cleared.
- `start` sampled at edge 0 → SHIFT from cycle 1; `word_ready` high in cycle 1.
- With `word_valid` held high, the last accept is in cycle `CHAIN_LEN`. COMMIT is in cycle `CHAIN_LEN+1`.
- In cycle `CHAIN_LEN+2`, `cfg_q` shows the new value and `done`=1 together. The state is IDLE in cycle `CHAIN_LEN+3`.
- Minimum load-to-load latency: `CHAIN_LEN+3` cycles (start can be reasserted in the cycle the state is IDLE).
- All outputs are registered or decoded from state only. There is no combinational path from `word_valid` to `word_ready`.

## Structure
- Package `cfg_scan_pkg`: state enum (IDLE, SHIFT, COMMIT, DONE), default `NUM_CHAINS`/`CHAIN_LEN` constants, counter-width function.
- Sub-module `cfg_scan_lane`:
  - one chain plus its shadow register;
  - inputs: `CK`, `RST`, `shift_en`, `commit_en`, `si`;
  - outputs: `so`, `q[CHAIN_LEN]`;
  - instantiated `NUM_CHAINS` times by a generate loop.
- The top level holds the FSM, counter and handshake only.

## Test plan
- **Basic load:** `NUM_CHAINS`=4, `CHAIN_LEN`=16, reset, then start. Stream 16 words with chain c's bit k = bit (15-k) of 16'hA5C3 rotated left by c. Expect chain 0 `cfg_q` = 16'hA5C3; `done` in cycle 18 after start; `busy` falls in cycle 19.
- **Backpressure gaps:** same stream with `word_valid` low every other cycle. Expect identical `cfg_q`; `done` in cycle 33.
- **Abort:** load 16'hFFFF into all chains, then start a new load. After 5 accepts, assert `abort` with `word_valid`=1. Expect the 6th word not shifted, IDLE next cycle, `cfg_q` still all-ones, no `done`.
- **Readback:** after the basic load, run a second load of zeros. Expect `scan_out[0]` to emit 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on successive accepts.
- **Reset mid-shift:** assert `RST` during accept #8. Expect all outputs 0 next cycle, state IDLE, and `start` accepted the cycle after.
- **Ignored controls:** `start` pulsed during SHIFT and COMMIT has no effect (`done` count 1). `start` and `abort` together in IDLE: remains IDLE.
